// File: rtl/pipelined_array_multiplier.sv
// Pipelined DATA_WIDTH x DATA_WIDTH array multiplier: each stage retires PRODUCT_PER_STAGE rows.
// Define PIPELINED_MUL_SIGNED_EN to add the signed_i port and two's-complement operation.
module pipelined_array_multiplier #(
    parameter int unsigned DATA_WIDTH        = 32,
    parameter int unsigned PRODUCT_PER_STAGE = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    flush_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    input  logic [DATA_WIDTH-1:0]   multiplicand_i,
    input  logic [DATA_WIDTH-1:0]   multiplier_i,
`ifdef PIPELINED_MUL_SIGNED_EN
    input  logic                    signed_i,
`endif
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic [2*DATA_WIDTH-1:0] product_o
);
    localparam int unsigned STAGES = DATA_WIDTH / PRODUCT_PER_STAGE;
    localparam int unsigned PP_W   = DATA_WIDTH - 1;
    localparam int unsigned LAST   = STAGES - 1;

    logic                    w_advance;
    logic [DATA_WIDTH-1:0]   w_a_mag;
    logic [DATA_WIDTH-1:0]   w_b_mag;
    logic [2*DATA_WIDTH-1:0] w_raw;

`ifdef PIPELINED_MUL_SIGNED_EN
    logic w_sign;

    // Pipe works on magnitudes; the sign rides along and is applied at the end.
    always_comb begin
        w_sign  = signed_i & (multiplicand_i[DATA_WIDTH-1] ^ multiplier_i[DATA_WIDTH-1]);
        w_a_mag = (signed_i && multiplicand_i[DATA_WIDTH-1]) ? -multiplicand_i : multiplicand_i;
        w_b_mag = (signed_i && multiplier_i[DATA_WIDTH-1]) ? -multiplier_i : multiplier_i;
    end
`else
    assign w_a_mag = multiplicand_i;
    assign w_b_mag = multiplier_i;
`endif

    assign w_advance = ~valid_o | ready_i;
    assign ready_o   = w_advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int unsigned BW = DATA_WIDTH - k * PRODUCT_PER_STAGE;
        localparam int unsigned LW = (k + 1) * PRODUCT_PER_STAGE;

        logic [DATA_WIDTH-1:0]        w_a_in;
        logic [BW-1:0]                w_b_in;
        logic [PP_W-1:0]              w_pp_in;
        logic                         w_carry_in;
        logic                         w_valid_in;
        logic [DATA_WIDTH-1:0]        w_acc;
        logic [DATA_WIDTH:0]          w_sum;
        logic [PRODUCT_PER_STAGE-1:0] w_bits;
        logic [LW-1:0]                w_low_out;

        logic [PP_W-1:0]              r_pp;
        logic                         r_carry;
        logic [LW-1:0]                r_low;
        logic                         r_valid;
`ifdef PIPELINED_MUL_SIGNED_EN
        logic                         w_sign_in;
        logic                         r_sign;
`endif

        if (k == 0) begin : g_head
            assign w_a_in     = w_a_mag;
            assign w_b_in     = w_b_mag;
            assign w_pp_in    = '0;
            assign w_carry_in = 1'b0;
            assign w_valid_in = valid_i;
            assign w_low_out  = w_bits;
`ifdef PIPELINED_MUL_SIGNED_EN
            assign w_sign_in  = w_sign;
`endif
        end else begin : g_body
            assign w_a_in     = g_stage[k-1].g_fwd.r_a;
            assign w_b_in     = g_stage[k-1].g_fwd.r_b;
            assign w_pp_in    = g_stage[k-1].r_pp;
            assign w_carry_in = g_stage[k-1].r_carry;
            assign w_valid_in = g_stage[k-1].r_valid;
            assign w_low_out  = {w_bits, g_stage[k-1].r_low};
`ifdef PIPELINED_MUL_SIGNED_EN
            assign w_sign_in  = g_stage[k-1].r_sign;
`endif
        end

        // Each row adds A (if its B bit is set) to the running sum, then retires the LSB.
        always_comb begin
            w_acc  = {w_carry_in, w_pp_in};
            w_sum  = '0;
            w_bits = '0;
            for (int j = 0; j < PRODUCT_PER_STAGE; j++) begin
                w_sum     = {1'b0, w_acc} + (w_b_in[j] ? {1'b0, w_a_in} : '0);
                w_bits[j] = w_sum[0];
                w_acc     = w_sum[DATA_WIDTH:1];
            end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                r_valid <= 1'b0;
                r_pp    <= '0;
                r_carry <= 1'b0;
                r_low   <= '0;
`ifdef PIPELINED_MUL_SIGNED_EN
                r_sign  <= 1'b0;
`endif
            end else begin
                if (flush_i) begin
                    r_valid <= 1'b0;
                end else if (w_advance) begin
                    r_valid <= w_valid_in;
                end
                if (w_advance) begin
                    r_pp    <= w_acc[PP_W-1:0];
                    r_carry <= w_acc[DATA_WIDTH-1];
                    r_low   <= w_low_out;
`ifdef PIPELINED_MUL_SIGNED_EN
                    r_sign  <= w_sign_in;
`endif
                end
            end
        end

        // Operands only need forwarding to stages that still have rows to process.
        if (k < LAST) begin : g_fwd
            logic [DATA_WIDTH-1:0]              r_a;
            logic [BW-PRODUCT_PER_STAGE-1:0]    r_b;

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_advance) begin
                    r_a <= w_a_in;
                    r_b <= w_b_in[BW-1:PRODUCT_PER_STAGE];
                end
            end
        end
    end

    assign w_raw   = {g_stage[LAST].r_carry, g_stage[LAST].r_pp, g_stage[LAST].r_low};
    assign valid_o = g_stage[LAST].r_valid;

`ifdef PIPELINED_MUL_SIGNED_EN
    assign product_o = g_stage[LAST].r_sign ? -w_raw : w_raw;
`else
    assign product_o = w_raw;
`endif

endmodule

// File: tb/tb_pipelined_array_multiplier.sv
// Self-checking bench for pipelined_array_multiplier (DATA_WIDTH=8, PRODUCT_PER_STAGE=4).
module tb_pipelined_array_multiplier;
    localparam int DW = 8;
    localparam int PPS = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic flush = 1'b0;
    logic valid_in = 1'b0;
    logic ready_out;
    logic [DW-1:0] a = '0;
    logic [DW-1:0] b = '0;
    logic sgn = 1'b0;
    logic valid_out;
    logic ready_in = 1'b0;
    logic [2*DW-1:0] prod;

    logic [2*DW-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    pipelined_array_multiplier #(
        .DATA_WIDTH(DW),
        .PRODUCT_PER_STAGE(PPS)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .flush_i(flush),
        .valid_i(valid_in),
        .ready_o(ready_out),
        .multiplicand_i(a),
        .multiplier_i(b),
`ifdef PIPELINED_MUL_SIGNED_EN
        .signed_i(sgn),
`endif
        .valid_o(valid_out),
        .ready_i(ready_in),
        .product_o(prod)
    );

    function automatic logic [2*DW-1:0] ref_mul(input logic [DW-1:0] x, input logic [DW-1:0] y,
                                                input logic s);
        logic [2*DW-1:0] xe;
        logic [2*DW-1:0] ye;
        xe = s ? {{DW{x[DW-1]}}, x} : {{DW{1'b0}}, x};
        ye = s ? {{DW{y[DW-1]}}, y} : {{DW{1'b0}}, y};
        return xe * ye;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if (valid_out !== 1'b0) $display("FAIL reset_valid got %b want 0", valid_out);
        else n_pass++;
        n_checks++;
        if (prod !== 16'h0) $display("FAIL reset_product got %h want 0000", prod);
        else n_pass++;
        n_checks++;
        if (ready_out !== 1'b1) $display("FAIL reset_ready got %b want 1", ready_out);
        else n_pass++;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        ready_in = 1'b1;
        valid_in = 1'b1; a = 8'hFF; b = 8'hFF;
        tick();
        valid_in = 1'b0;
        n_checks++;
        if (valid_out !== 1'b0) $display("FAIL single_early got valid %b want 0", valid_out);
        else n_pass++;
        tick();
        n_checks++;
        if (valid_out !== 1'b1 || prod !== 16'hFE01)
            $display("FAIL single_result got v=%b p=%h want v=1 p=fe01", valid_out, prod);
        else n_pass++;
        tick();
        n_checks++;
        if (valid_out !== 1'b0) $display("FAIL single_after got valid %b want 0", valid_out);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] av[3] = '{8'd3, 8'h80, 8'h00};
        logic [DW-1:0] bv[3] = '{8'd5, 8'h02, 8'h7F};
        logic [2*DW-1:0] e;
        int first = -1;
        int last = -1;
        int outs = 0;
        ready_in = 1'b1;
        exp_q.delete();
        for (int it = 0; it < 8; it++) begin
            valid_in = (it < 3);
            if (it < 3) begin a = av[it]; b = bv[it]; end
            #1;
            if (valid_in && ready_out) exp_q.push_back(ref_mul(a, b, 1'b0));
            if (valid_out && ready_in) begin
                if (first < 0) first = it;
                last = it;
                outs++;
                n_checks++;
                if (exp_q.size() == 0) $display("FAIL b2b_extra got %h want none", prod);
                else begin
                    e = exp_q.pop_front();
                    if (prod !== e) $display("FAIL b2b_value got %h want %h", prod, e);
                    else n_pass++;
                end
            end
            tick();
        end
        valid_in = 1'b0;
        n_checks++;
        if (outs !== 3 || first !== 2 || last !== 4)
            $display("FAIL b2b_timing got outs=%0d first=%0d last=%0d want 3 2 4", outs, first, last);
        else n_pass++;
    endtask

    task automatic test_stall();
        logic [DW-1:0] av[4] = '{8'd7, 8'hFF, 8'h10, 8'hAB};
        logic [DW-1:0] bv[4] = '{8'd9, 8'h01, 8'h10, 8'hCD};
        logic [2*DW-1:0] e;
        int idx = 0;
        int outs = 0;
        exp_q.delete();
        for (int it = 0; it < 30; it++) begin
            ready_in = (it >= 6);
            valid_in = (idx < 4);
            if (idx < 4) begin a = av[idx]; b = bv[idx]; end
            #1;
            if (it >= 2 && it < 6) begin
                n_checks++;
                if (ready_out !== 1'b0 || valid_out !== 1'b1 || exp_q.size() == 0 ||
                    prod !== exp_q[0])
                    $display("FAIL stall_hold got r=%b v=%b p=%h want r=0 v=1 p=%h",
                             ready_out, valid_out, prod, 16'd63);
                else n_pass++;
            end
            if (valid_in && ready_out) begin
                exp_q.push_back(ref_mul(a, b, 1'b0));
                idx++;
            end
            if (valid_out && ready_in) begin
                outs++;
                n_checks++;
                if (exp_q.size() == 0) $display("FAIL stall_extra got %h want none", prod);
                else begin
                    e = exp_q.pop_front();
                    if (prod !== e) $display("FAIL stall_drain got %h want %h", prod, e);
                    else n_pass++;
                end
            end
            tick();
        end
        valid_in = 1'b0;
        n_checks++;
        if (outs !== 4 || exp_q.size() !== 0)
            $display("FAIL stall_count got %0d outs %0d left want 4 0", outs, exp_q.size());
        else n_pass++;
    endtask

    task automatic test_reset_midflight();
        bit seen = 1'b0;
        ready_in = 1'b0;
        valid_in = 1'b1; a = 8'd9; b = 8'd9;
        tick();
        a = 8'd10; b = 8'd10;
        tick();
        valid_in = 1'b0;
        rst = 1'b1;
        #1;
        n_checks++;
        if (valid_out !== 1'b0 || prod !== 16'h0 || ready_out !== 1'b1)
            $display("FAIL midrst_now got v=%b p=%h r=%b want v=0 p=0000 r=1",
                     valid_out, prod, ready_out);
        else n_pass++;
        tick();
        rst = 1'b0;
        ready_in = 1'b1;
        for (int it = 0; it < 5; it++) begin
            tick();
            if (valid_out) seen = 1'b1;
        end
        n_checks++;
        if (seen) $display("FAIL midrst_ghost got valid_o=1 want 0");
        else n_pass++;
    endtask

    task automatic test_flush();
        ready_in = 1'b0;
        valid_in = 1'b1; a = 8'd11; b = 8'd3;
        tick();
        a = 8'd12;
        tick();
        n_checks++;
        if (valid_out !== 1'b1) $display("FAIL flush_full got valid %b want 1", valid_out);
        else n_pass++;
        flush = 1'b1; a = 8'd13;
        tick();
        flush = 1'b0;
        valid_in = 1'b0;
        n_checks++;
        if (valid_out !== 1'b0) $display("FAIL flush_clear got valid %b want 0", valid_out);
        else n_pass++;
        ready_in = 1'b1;
        valid_in = 1'b1; a = 8'd5; b = 8'd7;
        tick();
        valid_in = 1'b0;
        n_checks++;
        if (valid_out !== 1'b0) $display("FAIL flush_stale got valid %b want 0", valid_out);
        else n_pass++;
        tick();
        n_checks++;
        if (valid_out !== 1'b1 || prod !== 16'h0023)
            $display("FAIL flush_next got v=%b p=%h want v=1 p=0023", valid_out, prod);
        else n_pass++;
        tick();
    endtask

`ifdef PIPELINED_MUL_SIGNED_EN
    task automatic test_signed();
        logic [DW-1:0] av[3] = '{8'hFD, 8'h80, 8'hFF};
        logic [DW-1:0] bv[3] = '{8'h05, 8'h80, 8'hFF};
        logic sv[3] = '{1'b1, 1'b1, 1'b0};
        logic [2*DW-1:0] ev[3] = '{16'hFFF1, 16'h4000, 16'hFE01};
        logic [2*DW-1:0] e;
        int idx = 0;
        ready_in = 1'b1;
        exp_q.delete();
        for (int it = 0; it < 8; it++) begin
            valid_in = (it < 3);
            if (it < 3) begin a = av[it]; b = bv[it]; sgn = sv[it]; end
            #1;
            if (valid_in && ready_out) begin
                exp_q.push_back(ev[idx]);
                idx++;
            end
            if (valid_out && ready_in) begin
                n_checks++;
                if (exp_q.size() == 0) $display("FAIL signed_extra got %h want none", prod);
                else begin
                    e = exp_q.pop_front();
                    if (prod !== e) $display("FAIL signed_value got %h want %h", prod, e);
                    else n_pass++;
                end
            end
            tick();
        end
        valid_in = 1'b0;
        sgn = 1'b0;
        n_checks++;
        if (exp_q.size() !== 0) $display("FAIL signed_lost got %0d left want 0", exp_q.size());
        else n_pass++;
    endtask
`endif

    task automatic test_random();
        localparam int NOPS = 10000;
        logic [2*DW-1:0] e;
        int sent = 0;
        int outs = 0;
        int it = 0;
        exp_q.delete();
        while ((sent < NOPS || outs < NOPS) && it < 60000) begin
            ready_in = ($urandom_range(0, 9) < 7);
            valid_in = (sent < NOPS) && ($urandom_range(0, 3) != 0);
            a = DW'($urandom);
            b = DW'($urandom);
`ifdef PIPELINED_MUL_SIGNED_EN
            sgn = $urandom_range(0, 1) == 1;
`endif
            #1;
            if (valid_in && ready_out) begin
                exp_q.push_back(ref_mul(a, b, sgn));
                sent++;
            end
            if (valid_out && ready_in) begin
                outs++;
                n_checks++;
                if (exp_q.size() == 0) $display("FAIL rand_extra got %h want none", prod);
                else begin
                    e = exp_q.pop_front();
                    if (prod !== e) $display("FAIL rand_value got %h want %h", prod, e);
                    else n_pass++;
                end
            end
            tick();
            it++;
        end
        valid_in = 1'b0;
        sgn = 1'b0;
        n_checks++;
        if (sent !== NOPS || outs !== NOPS)
            $display("FAIL rand_count got sent=%0d outs=%0d want %0d each", sent, outs, NOPS);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_reset_midflight();
        test_flush();
`ifdef PIPELINED_MUL_SIGNED_EN
        test_signed();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
